// File: rtl/fwd_pkg.sv
// Shared types for the forwarding / load-use hazard unit.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package fwd_pkg;

    // Slot rd field is sized for the widest register address we support.
    // Narrower addresses are zero-extended on the way in.
    localparam int RD_W_MAX        = 8;
    localparam int FWD_SEL_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [RD_W_MAX-1:0] rd;
        logic                regwrite;
        logic                memread;
    } slot_t;

    // Width of a forward select able to encode 0 (regfile) .. stages.
    function automatic int fwd_sel_w(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Youngest-hit priority encoder for one source operand over the in-flight slots.
// Latency: combinational.
// Backpressure: none; is_load_hit_within_lat feeds the unit's stall.
//
// Ports:
//   slots                   in   in-flight slots, index 0 = EX (youngest)
//   rs                      in   operand source address
//   sel                     out  0 = regfile, k = stage k after EX
//   is_load_hit_within_lat  out  youngest hit is a load not yet forwardable
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int SEL_W      = 2
) (
    input  slot_t [FWD_STAGES:0]  slots,
    input  logic [REG_ADDR_W-1:0] rs,
    output logic [SEL_W-1:0]      sel,
    output logic                  is_load_hit_within_lat
);

    logic [RD_W_MAX-1:0] rs_ext;
    logic                found;

    assign rs_ext = RD_W_MAX'(rs);

    always_comb begin
        sel                    = '0;
        is_load_hit_within_lat = 1'b0;
        found                  = 1'b0;
        for (int s = 0; s <= FWD_STAGES; s++) begin
            if (!found && slots[s].valid && slots[s].regwrite &&
                slots[s].rd != '0 && slots[s].rd == rs_ext) begin
                found = 1'b1;
                // The oldest slot has already written the write-first regfile,
                // so a hit there (with nothing younger) reads the regfile.
                if (s == FWD_STAGES) begin
                    sel = SEL_W'(FWD_SEL_REGFILE);
                end else begin
                    sel = SEL_W'(s + 1);
                end
                is_load_hit_within_lat = slots[s].memread && (s < LOAD_LAT);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select + load-use hazard unit between decode and the EX operand muxes.
// Latency: forward selects registered ID->EX in 1 cycle; stall is combinational.
// Backpressure: stall holds PC and IF/ID and inserts a bubble; downstream slots never stall.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   id_valid/id_rs/id_rd           ID instruction, operand i at id_rs[i*REG_ADDR_W +: REG_ADDR_W]
//   id_regwrite/id_memread         ID instruction writes rd / is a load
//   flush                          kill the ID instruction
//   stall                          hold front end (combinational)
//   ex_valid, ex_fwd_sel           EX occupancy and per-operand forward selects
//   stall_cnt, fwd_cnt             saturating statistics, only with FWD_HAZARD_STATS_EN defined
// REG_ADDR_W must not exceed fwd_pkg::RD_W_MAX.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int  REG_ADDR_W = 5,
    parameter int  NUM_SRC    = 2,
    parameter int  FWD_STAGES = 2,
    parameter int  LOAD_LAT   = 1,
    localparam int SEL_W      = fwd_sel_w(FWD_STAGES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    input  logic                          flush,
    output logic                          stall,
    output logic                          ex_valid,
    output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   fwd_cnt
`endif
);

    slot_t [FWD_STAGES:0]       slot_q;
    slot_t                      id_slot;
    logic [NUM_SRC*SEL_W-1:0]   sel_all;
    logic [NUM_SRC-1:0]         load_hit;
    logic                       load_en;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .FWD_STAGES (FWD_STAGES),
            .LOAD_LAT   (LOAD_LAT),
            .SEL_W      (SEL_W)
        ) u_match (
            .slots                  (slot_q),
            .rs                     (id_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .sel                    (sel_all[i*SEL_W +: SEL_W]),
            .is_load_hit_within_lat (load_hit[i])
        );
    end

    // Flush wins over a pending load-use stall.
    assign stall    = id_valid & ~flush & (|load_hit);
    assign load_en  = id_valid & ~stall & ~flush;
    assign ex_valid = slot_q[0].valid;

    always_comb begin
        id_slot          = '0;
        id_slot.valid    = load_en;
        id_slot.rd       = RD_W_MAX'(id_rd);
        id_slot.regwrite = id_regwrite;
        id_slot.memread  = id_memread;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q     <= '0;
            ex_fwd_sel <= '0;
        end else begin
            slot_q[0] <= id_slot;
            for (int k = 1; k <= FWD_STAGES; k++) begin
                slot_q[k] <= slot_q[k-1];
            end
            ex_fwd_sel <= load_en ? sel_all : '0;
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    // Each instruction occupies EX for exactly one cycle, so counting EX
    // cycles with a nonzero select counts forwarded instructions.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ex_valid && (|ex_fwd_sel) && fwd_cnt != '1) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two configurations (2 src / 2 stages / LOAD_LAT 1 and
// 3 src / 3 stages / LOAD_LAT 2) driven with the same directed and random stream.
// Statistics counters are checked when FWD_HAZARD_STATS_EN is defined.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic       id_regwrite = 1'b0;
    logic       id_memread = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] id_rd = '0;
    logic [4:0] rs0 = '0;
    logic [4:0] rs1 = '0;
    logic [4:0] rs2 = '0;

    logic       stall_a, ex_valid_a;
    logic [3:0] sel_a;
    logic       stall_b, ex_valid_b;
    logic [5:0] sel_b;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] stall_cnt_a, fwd_cnt_a, stall_cnt_b, fwd_cnt_b;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_LAT(1)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       ({rs1, rs0}),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall_a),
        .ex_valid    (ex_valid_a),
        .ex_fwd_sel  (sel_a)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stall_cnt   (stall_cnt_a),
        .fwd_cnt     (fwd_cnt_a)
`endif
    );

    fwd_hazard_unit #(.REG_ADDR_W(5), .NUM_SRC(3), .FWD_STAGES(3), .LOAD_LAT(2)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       ({rs2, rs1, rs0}),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .stall       (stall_b),
        .ex_valid    (ex_valid_b),
        .ex_fwd_sel  (sel_b)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stall_cnt   (stall_cnt_b),
        .fwd_cnt     (fwd_cnt_b)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // History of every instruction that entered EX, stamped with the cycle it
    // entered. An instruction that entered at cycle e is d = now - e stages
    // past EX during cycle now.
    typedef struct {
        int enter;
        int rd;
        bit rw;
        bit mr;
    } rec_t;

    rec_t hist_a[$];
    rec_t hist_b[$];
    int   cyc = 0;
    bit   seen_rst = 0;
    int   expv_a = 0;
    int   expv_b = 0;
    int   exps_a[3] = '{0, 0, 0};
    int   exps_b[3] = '{0, 0, 0};

    function automatic void youngest(input rec_t h[$], input int now, input int fs,
                                     input int ll, input int rs,
                                     output int sel, output bit ld);
        int best;
        bit bmr;
        best = -1;
        bmr  = 0;
        foreach (h[j]) begin
            int d;
            d = now - h[j].enter;
            if (d >= 0 && d < fs && h[j].rw && h[j].rd != 0 && h[j].rd == rs &&
                (best < 0 || d < best)) begin
                best = d;
                bmr  = h[j].mr;
            end
        end
        sel = (best < 0) ? 0 : best + 1;
        ld  = (best >= 0) && bmr && (best < ll);
    endfunction

    always @(negedge clk) begin
        int  s_a[3];
        int  s_b[3];
        int  rsv[3];
        bit  l, ld_a, ld_b, st_a, st_b, en_a, en_b;
        rsv[0] = int'(rs0);
        rsv[1] = int'(rs1);
        rsv[2] = int'(rs2);
        if (reset) begin
            hist_a.delete();
            hist_b.delete();
            expv_a = 0;
            expv_b = 0;
            exps_a = '{0, 0, 0};
            exps_b = '{0, 0, 0};
            seen_rst = 1;
        end else if (seen_rst) begin
            ld_a = 0;
            s_a[2] = 0;
            for (int i = 0; i < 2; i++) begin
                youngest(hist_a, cyc, 2, 1, rsv[i], s_a[i], l);
                ld_a |= l;
            end
            st_a = id_valid && !flush && ld_a;
            chk("stall_a", int'(stall_a), int'(st_a));
            chk("ex_valid_a", int'(ex_valid_a), expv_a);
            for (int i = 0; i < 2; i++)
                chk($sformatf("sel_a[%0d]", i), int'(sel_a[i*2 +: 2]), exps_a[i]);
            en_a = id_valid && !st_a && !flush;
            if (en_a) hist_a.push_back('{cyc + 1, int'(id_rd), id_regwrite, id_memread});
            expv_a = int'(en_a);
            if (en_a) exps_a = s_a;
            else      exps_a = '{0, 0, 0};

            ld_b = 0;
            for (int i = 0; i < 3; i++) begin
                youngest(hist_b, cyc, 3, 2, rsv[i], s_b[i], l);
                ld_b |= l;
            end
            st_b = id_valid && !flush && ld_b;
            chk("stall_b", int'(stall_b), int'(st_b));
            chk("ex_valid_b", int'(ex_valid_b), expv_b);
            for (int i = 0; i < 3; i++)
                chk($sformatf("sel_b[%0d]", i), int'(sel_b[i*2 +: 2]), exps_b[i]);
            en_b = id_valid && !st_b && !flush;
            if (en_b) hist_b.push_back('{cyc + 1, int'(id_rd), id_regwrite, id_memread});
            expv_b = int'(en_b);
            if (en_b) exps_b = s_b;
            else      exps_b = '{0, 0, 0};

            while (hist_a.size() > 0 && hist_a[0].enter < cyc - 8) void'(hist_a.pop_front());
            while (hist_b.size() > 0 && hist_b[0].enter < cyc - 8) void'(hist_b.pop_front());
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    // Drives one ID instruction just after a rising edge, then returns 1 time
    // unit later so hand-computed checks sample settled outputs.
    task automatic drv(input bit v, input int rd, input bit rw, input bit mr,
                       input int r0, input int r1, input bit fl);
        @(posedge clk);
        #1;
        id_valid    = v;
        id_rd       = 5'(rd);
        id_regwrite = rw;
        id_memread  = mr;
        rs0         = 5'(r0);
        rs1         = 5'(r1);
        rs2         = '0;
        flush       = fl;
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Pins DUT A's EX outputs and the model's view of them to literals.
    task automatic lit_a(input string name, input int v, input int s0, input int s1);
        chk({name, "_dut_v"},   int'(ex_valid_a), v);
        chk({name, "_dut_s0"},  int'(sel_a[1:0]), s0);
        chk({name, "_dut_s1"},  int'(sel_a[3:2]), s1);
        chk({name, "_mdl_v"},   expv_a, v);
        chk({name, "_mdl_s0"},  exps_a[0], s0);
        chk({name, "_mdl_s1"},  exps_a[1], s1);
    endtask

`ifdef FWD_HAZARD_STATS_EN
    int sc_a0, fc_a0, sc_b0, fc_b0;
`endif

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_ex_valid", int'(ex_valid_a), 0);
        chk("rst_sel", int'(sel_a), 0);
        chk("rst_stall", int'(stall_a), 0);
`ifdef FWD_HAZARD_STATS_EN
        chk("rst_stall_cnt", int'(stall_cnt_a), 0);
        chk("rst_fwd_cnt", int'(fwd_cnt_a), 0);
`endif

        // Back-to-back ALU dependency.
        drv(1, 5, 1, 0, 0, 0, 0);
        drv(1, 6, 1, 0, 5, 1, 0);
        chk("t1_stall", int'(stall_a), 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        lit_a("t1", 1, 1, 0);
        nops(4);

        // Distance 2 on both operands, then distance 3 (last slot, regfile).
        drv(1, 5, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(1, 7, 1, 0, 5, 5, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        lit_a("t2_d2", 1, 2, 2);
        drv(1, 10, 1, 0, 0, 0, 0);
        nops(2);
        drv(1, 11, 1, 0, 10, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        lit_a("t2_d3", 1, 0, 0);
        nops(4);

        // Load-use: held consumer for DUT A (LOAD_LAT 1).
        drv(1, 8, 1, 1, 0, 0, 0);
`ifdef FWD_HAZARD_STATS_EN
        sc_a0 = int'(stall_cnt_a);
        fc_a0 = int'(fwd_cnt_a);
        sc_b0 = int'(stall_cnt_b);
        fc_b0 = int'(fwd_cnt_b);
`endif
        chk("t3_stall0", int'(stall_a), 0);
        drv(1, 9, 1, 0, 8, 0, 0);
        chk("t3_stall1", int'(stall_a), 1);
        chk("t3b_stall1", int'(stall_b), 1);
        drv(1, 9, 1, 0, 8, 0, 0);
        chk("t3_stall2", int'(stall_a), 0);
        chk("t3_bubble", int'(ex_valid_a), 0);
        chk("t3b_stall2", int'(stall_b), 1);
        drv(0, 0, 0, 0, 0, 0, 0);
        lit_a("t3", 1, 2, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
`ifdef FWD_HAZARD_STATS_EN
        chk("t3_stall_cnt_a", int'(stall_cnt_a) - sc_a0, 1);
        chk("t3_fwd_cnt_a", int'(fwd_cnt_a) - fc_a0, 1);
        chk("t3_stall_cnt_b", int'(stall_cnt_b) - sc_b0, 2);
        chk("t3_fwd_cnt_b", int'(fwd_cnt_b) - fc_b0, 0);
`endif
        nops(4);

        // Load-use for DUT B (LOAD_LAT 2): two stall cycles, then sel 3.
        drv(1, 12, 1, 1, 0, 0, 0);
        drv(1, 13, 1, 0, 12, 0, 0);
        chk("t3b_l2_stall1", int'(stall_b), 1);
        drv(1, 13, 1, 0, 12, 0, 0);
        chk("t3b_l2_stall2", int'(stall_b), 1);
        drv(1, 13, 1, 0, 12, 0, 0);
        chk("t3b_l2_stall3", int'(stall_b), 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("t3b_l2_valid", int'(ex_valid_b), 1);
        chk("t3b_l2_sel", int'(sel_b[1:0]), 3);
        nops(4);

        // Priority: youngest producer wins; x0 never forwards or stalls.
        drv(1, 5, 1, 0, 0, 0, 0);
        drv(1, 5, 1, 0, 0, 0, 0);
        drv(1, 4, 1, 0, 5, 5, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        lit_a("t4_prio", 1, 1, 1);
        drv(1, 0, 1, 1, 0, 0, 0);
        drv(1, 3, 1, 0, 0, 0, 0);
        chk("t4_x0_stall", int'(stall_a), 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        lit_a("t4_x0", 1, 0, 0);
        nops(4);

        // Flush beats a load-use stall.
        drv(1, 8, 1, 1, 0, 0, 0);
        drv(1, 9, 1, 0, 8, 0, 1);
        chk("t5_flush_stall", int'(stall_a), 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("t5_flush_valid", int'(ex_valid_a), 0);
        nops(4);

        // Reset in the middle of a stall.
        drv(1, 8, 1, 1, 0, 0, 0);
        drv(1, 9, 1, 0, 8, 0, 0);
        chk("t5_pre_rst_stall", int'(stall_a), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_rst_stall", int'(stall_a), 0);
        chk("t5_rst_valid", int'(ex_valid_a), 0);
        chk("t5_rst_sel", int'(sel_a), 0);
        chk("t5_rst_stall_b", int'(stall_b), 0);
        chk("t5_rst_sel_b", int'(sel_b), 0);
        nops(4);

        // Random streams on a small register set to provoke frequent hits.
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rd       = 5'($urandom_range(0, 7));
            id_regwrite = ($urandom_range(0, 4) != 0);
            id_memread  = ($urandom_range(0, 2) == 0);
            rs0         = 5'($urandom_range(0, 7));
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 9) == 0);
        end
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        flush    = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
